// File: rtl/axi_burst_ram_slave_if.sv
// AXI3-subset bus bundle between a cache master and axi_burst_ram_slave.
interface axi_burst_ram_slave_if;
    logic [3:0]  s_arid;
    logic [31:0] s_araddr;
    logic [3:0]  s_arlen;
    logic [1:0]  s_arburst;
    logic        s_arvalid;
    logic        s_arready;
    logic [3:0]  s_rid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        s_rvalid;
    logic        s_rready;
    logic [3:0]  s_awid;
    logic [31:0] s_awaddr;
    logic [3:0]  s_awlen;
    logic [1:0]  s_awburst;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wlast;
    logic        s_wvalid;
    logic        s_wready;
    logic [3:0]  s_bid;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;

    modport slave (
        input  s_arid, s_araddr, s_arlen, s_arburst, s_arvalid, s_rready,
        input  s_awid, s_awaddr, s_awlen, s_awburst, s_awvalid,
        input  s_wdata, s_wstrb, s_wlast, s_wvalid, s_bready,
        output s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        output s_awready, s_wready, s_bid, s_bresp, s_bvalid
    );

    modport master (
        output s_arid, s_araddr, s_arlen, s_arburst, s_arvalid, s_rready,
        output s_awid, s_awaddr, s_awlen, s_awburst, s_awvalid,
        output s_wdata, s_wstrb, s_wlast, s_wvalid, s_bready,
        input  s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        input  s_awready, s_wready, s_bid, s_bresp, s_bvalid
    );
endinterface

// File: rtl/axi_burst_ram_slave.sv
// AXI3-subset burst RAM responder: one transaction at a time, read wins over write, INCR/FIXED bursts.
// Define AXI_SLAVE_STALL_EN to insert STALL_CYCLES wait states at every handshake point.
module axi_burst_ram_slave #(
    parameter int unsigned MEM_AW       = 14,
    parameter int unsigned STALL_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    axi_burst_ram_slave_if.slave  axi
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RD_BURST = 2'd1;
    localparam logic [1:0] WR_DATA  = 2'd2;
    localparam logic [1:0] WR_RESP  = 2'd3;

    logic [31:0]       mem [2**MEM_AW];
    logic [1:0]        state;
    logic [MEM_AW-1:0] idx;
    logic [MEM_AW-1:0] idx_next;
    logic [MEM_AW-1:0] ar_idx;
    logic [MEM_AW-1:0] aw_idx;
    logic [3:0]        len;
    logic [3:0]        cnt;
    logic [3:0]        rid_q;
    logic [3:0]        bid_q;
    logic [31:0]       rdata_q;
    logic              fixed;
    logic              err;
    logic              at_last;
    logic              stall_ok;
    logic              hs_ar, hs_aw, hs_r, hs_w, hs_b;
    logic              unused_addr;

    assign ar_idx      = axi.s_araddr[MEM_AW+1:2];
    assign aw_idx      = axi.s_awaddr[MEM_AW+1:2];
    assign unused_addr = ^{axi.s_araddr, axi.s_awaddr};
    assign idx_next    = fixed ? idx : idx + MEM_AW'(1);
    assign at_last     = (cnt == len);

    assign axi.s_arready = (state == IDLE) && stall_ok;
    assign axi.s_awready = (state == IDLE) && !axi.s_arvalid && stall_ok;
    assign axi.s_rvalid  = (state == RD_BURST) && stall_ok;
    assign axi.s_rlast   = axi.s_rvalid && at_last;
    assign axi.s_rdata   = rdata_q;
    assign axi.s_rid     = rid_q;
    assign axi.s_rresp   = '0;
    assign axi.s_wready  = (state == WR_DATA) && stall_ok;
    assign axi.s_bvalid  = (state == WR_RESP) && stall_ok;
    assign axi.s_bid     = bid_q;
    assign axi.s_bresp   = (state == WR_RESP && err) ? 2'b10 : 2'b00;

    assign hs_ar = axi.s_arvalid && axi.s_arready;
    assign hs_aw = axi.s_awvalid && axi.s_awready;
    assign hs_r  = axi.s_rvalid && axi.s_rready;
    assign hs_w  = axi.s_wvalid && axi.s_wready;
    assign hs_b  = axi.s_bvalid && axi.s_bready;

`ifdef AXI_SLAVE_STALL_EN
    logic [7:0] wait_cnt;
    logic       wait_req;

    // Count restarts after every handshake, so each beat/response sees the full stall.
    assign wait_req = (state != IDLE) || axi.s_arvalid || axi.s_awvalid;
    assign stall_ok = (wait_cnt == 8'(STALL_CYCLES));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= '0;
        end else if (hs_ar || hs_aw || hs_r || hs_w || hs_b || !wait_req) begin
            wait_cnt <= '0;
        end else if (!stall_ok) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`else
    assign stall_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            idx     <= '0;
            len     <= '0;
            cnt     <= '0;
            fixed   <= 1'b0;
            err     <= 1'b0;
            rid_q   <= '0;
            bid_q   <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs_ar) begin
                        rid_q   <= axi.s_arid;
                        idx     <= ar_idx;
                        len     <= axi.s_arlen;
                        fixed   <= (axi.s_arburst == 2'b00);
                        cnt     <= '0;
                        rdata_q <= mem[ar_idx];
                        state   <= RD_BURST;
                    end else if (hs_aw) begin
                        bid_q <= axi.s_awid;
                        idx   <= aw_idx;
                        len   <= axi.s_awlen;
                        fixed <= (axi.s_awburst == 2'b00);
                        cnt   <= '0;
                        err   <= 1'b0;
                        state <= WR_DATA;
                    end
                end
                RD_BURST: begin
                    if (hs_r) begin
                        if (at_last) begin
                            state <= IDLE;
                        end else begin
                            cnt     <= cnt + 4'd1;
                            idx     <= idx_next;
                            rdata_q <= mem[idx_next];
                        end
                    end
                end
                WR_DATA: begin
                    if (hs_w) begin
                        // Burst length comes from awlen only; a misplaced wlast just flags SLVERR.
                        if (axi.s_wlast != at_last) err <= 1'b1;
                        if (at_last) begin
                            state <= WR_RESP;
                        end else begin
                            cnt <= cnt + 4'd1;
                            idx <= idx_next;
                        end
                    end
                end
                default: begin
                    if (hs_b) state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (hs_w) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (axi.s_wstrb[b]) mem[idx][8*b +: 8] <= axi.s_wdata[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi_burst_ram_slave.sv
// Directed bench for axi_burst_ram_slave: shadow-memory model plus expected-beat queue for reads.
module tb_axi_burst_ram_slave;
    localparam int unsigned MEM_AW = 14;
    localparam int unsigned DEPTH  = 1 << MEM_AW;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [3:0]  id;
    } rbeat_t;

    logic clk = 1'b0;
    logic resetn;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] model [int unsigned];
    rbeat_t      exp_q [$];

    always #5 clk = ~clk;

    axi_burst_ram_slave_if bus ();

    axi_burst_ram_slave #(.MEM_AW(MEM_AW), .STALL_CYCLES(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .axi    (bus)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish before 400000");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned widx(input logic [31:0] a);
        return int'(a[MEM_AW+1:2]);
    endfunction

    function automatic logic [31:0] mget(input int unsigned i);
        return model.exists(i) ? model[i] : 'x;
    endfunction

    task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic fixed);
        int n = 0;
        bus.s_awid    = id;
        bus.s_awaddr  = addr;
        bus.s_awlen   = len;
        bus.s_awburst = fixed ? 2'b00 : 2'b01;
        bus.s_awvalid = 1'b1;
        #1;
        while (!bus.s_awready && n < 20) begin tick(); n++; end
        check("aw_accept", 32'(bus.s_awready), 32'd1);
        tick();
        bus.s_awvalid = 1'b0;
    endtask

    // err_beat < 0: wlast on the true last beat; otherwise wlast only on beat err_beat.
    task automatic w_phase(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic fixed, input logic [31:0] base, input logic [3:0] strb,
                           input int err_beat, input logic [1:0] exp_bresp, input int bstall);
        int unsigned i = widx(addr);
        int n;
        logic [31:0] w;
        logic [31:0] d;
        bus.s_wvalid = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            d = base + 32'(b);
            bus.s_wdata = d;
            bus.s_wstrb = strb;
            bus.s_wlast = (err_beat >= 0) ? (b == err_beat) : (b == int'(len));
            n = 0;
            while (!bus.s_wready && n < 20) begin tick(); n++; end
            check("wready", 32'(bus.s_wready), 32'd1);
            w = mget(i);
            for (int k = 0; k < 4; k++) if (strb[k]) w[8*k +: 8] = d[8*k +: 8];
            model[i] = w;
            tick();
            if (!fixed) i = (i + 1) % DEPTH;
        end
        bus.s_wvalid = 1'b0;
        bus.s_wlast  = 1'b0;
        check("bvalid_latency", 32'(bus.s_bvalid), 32'd1);
        repeat (bstall) begin
            tick();
            check("bvalid_hold", 32'(bus.s_bvalid), 32'd1);
            check("bresp_hold", 32'(bus.s_bresp), 32'(exp_bresp));
        end
        bus.s_bready = 1'b1;
        check("bresp", 32'(bus.s_bresp), 32'(exp_bresp));
        check("bid", 32'(bus.s_bid), 32'(id));
        tick();
        bus.s_bready = 1'b0;
        check("bvalid_clear", 32'(bus.s_bvalid), 32'd0);
    endtask

    task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                      input logic fixed, input logic [31:0] base, input logic [3:0] strb,
                      input int err_beat, input logic [1:0] exp_bresp);
        aw_phase(id, addr, len, fixed);
        w_phase(id, addr, len, fixed, base, strb, err_beat, exp_bresp, 0);
    endtask

    // stall_beat < 0: rready held high throughout.
    task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                      input logic fixed, input int stall_beat, input int stall_len);
        int unsigned i = widx(addr);
        rbeat_t e;
        for (int b = 0; b <= int'(len); b++) begin
            exp_q.push_back('{data: mget(i), last: (b == int'(len)), id: id});
            if (!fixed) i = (i + 1) % DEPTH;
        end
        bus.s_arid    = id;
        bus.s_araddr  = addr;
        bus.s_arlen   = len;
        bus.s_arburst = fixed ? 2'b00 : 2'b01;
        bus.s_arvalid = 1'b1;
        bus.s_rready  = 1'b1;
        #1;
        check("ar_accept", 32'(bus.s_arready), 32'd1);
        tick();
        bus.s_arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            check("rvalid", 32'(bus.s_rvalid), 32'd1);
            e = exp_q.pop_front();
            check("rdata", bus.s_rdata, e.data);
            check("rlast", 32'(bus.s_rlast), 32'(e.last));
            check("rid", 32'(bus.s_rid), 32'(e.id));
            if (b == stall_beat) begin
                bus.s_rready = 1'b0;
                repeat (stall_len) begin
                    tick();
                    check("rvalid_hold", 32'(bus.s_rvalid), 32'd1);
                    check("rdata_hold", bus.s_rdata, e.data);
                    check("rlast_hold", 32'(bus.s_rlast), 32'(e.last));
                end
                bus.s_rready = 1'b1;
            end
            tick();
        end
        bus.s_rready = 1'b0;
        check("rvalid_end", 32'(bus.s_rvalid), 32'd0);
        check("arready_after", 32'(bus.s_arready), 32'd1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bus.s_arid = '0; bus.s_araddr = '0; bus.s_arlen = '0; bus.s_arburst = '0;
        bus.s_arvalid = 1'b0; bus.s_rready = 1'b0;
        bus.s_awid = '0; bus.s_awaddr = '0; bus.s_awlen = '0; bus.s_awburst = '0;
        bus.s_awvalid = 1'b0; bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_wlast = 1'b0;
        bus.s_wvalid = 1'b0; bus.s_bready = 1'b0;
        resetn = 1'b0;
        repeat (3) tick();

        check("rst_arready", 32'(bus.s_arready), 32'd1);
        check("rst_awready", 32'(bus.s_awready), 32'd1);
        check("rst_rvalid",  32'(bus.s_rvalid),  32'd0);
        check("rst_rlast",   32'(bus.s_rlast),   32'd0);
        check("rst_wready",  32'(bus.s_wready),  32'd0);
        check("rst_bvalid",  32'(bus.s_bvalid),  32'd0);
        check("rst_rdata",   bus.s_rdata,        32'd0);
        check("rst_rid",     32'(bus.s_rid),     32'd0);
        check("rst_bid",     32'(bus.s_bid),     32'd0);
        check("rst_bresp",   32'(bus.s_bresp),   32'd0);
        check("rst_rresp",   32'(bus.s_rresp),   32'd0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // Preload mem[8..15] = A0..A7 through the write channel, then full-line read.
        wr(4'h1, 32'h20, 4'd7, 1'b0, 32'hA0, 4'hF, -1, 2'b00);
        rd(4'h5, 32'h20, 4'd7, 1'b0, -1, 0);

        // Partial write onto a known word; single-beat read must carry rlast.
        wr(4'h2, 32'h0C, 4'd0, 1'b0, 32'h11223344, 4'hF, -1, 2'b00);
        aw_phase(4'h2, 32'h0C, 4'd0, 1'b0);
        w_phase(4'h2, 32'h0C, 4'd0, 1'b0, 32'hAABBCCDD, 4'b0011, -1, 2'b00, 3);
        check("partial_model", mget(3), 32'h1122CCDD);
        rd(4'h7, 32'h0C, 4'd0, 1'b0, -1, 0);

        // Simultaneous AR and AW: read first, AW accepted right after the read ends.
        bus.s_arid = 4'h3; bus.s_araddr = 32'h20; bus.s_arlen = 4'd1; bus.s_arburst = 2'b01;
        bus.s_awid = 4'h9; bus.s_awaddr = 32'h40; bus.s_awlen = 4'd0; bus.s_awburst = 2'b01;
        bus.s_arvalid = 1'b1; bus.s_awvalid = 1'b1; bus.s_rready = 1'b1;
        #1;
        check("both_arready", 32'(bus.s_arready), 32'd1);
        check("both_awready", 32'(bus.s_awready), 32'd0);
        tick();
        bus.s_arvalid = 1'b0;
        #1;
        check("both_rd_awready", 32'(bus.s_awready), 32'd0);
        check("both_rdata0", bus.s_rdata, 32'hA0);
        check("both_rlast0", 32'(bus.s_rlast), 32'd0);
        check("both_rid", 32'(bus.s_rid), 32'h3);
        tick();
        check("both_rdata1", bus.s_rdata, 32'hA1);
        check("both_rlast1", 32'(bus.s_rlast), 32'd1);
        tick();
        bus.s_rready = 1'b0;
        check("both_idle_rvalid", 32'(bus.s_rvalid), 32'd0);
        check("both_idle_awready", 32'(bus.s_awready), 32'd1);
        tick();
        bus.s_awvalid = 1'b0;
        check("both_wready", 32'(bus.s_wready), 32'd1);
        w_phase(4'h9, 32'h40, 4'd0, 1'b0, 32'hCAFE0001, 4'hF, -1, 2'b00, 0);
        rd(4'h9, 32'h40, 4'd0, 1'b0, -1, 0);

        // Backpressure mid-burst and on the last beat; FIXED burst repeats one word.
        rd(4'h4, 32'h20, 4'd7, 1'b0, 2, 3);
        rd(4'h4, 32'h20, 4'd7, 1'b0, 7, 2);
        rd(4'h8, 32'h24, 4'd3, 1'b1, -1, 0);

        // Early wlast and missing wlast both give SLVERR, data still written.
        wr(4'hA, 32'h100, 4'd3, 1'b0, 32'h5A5A0000, 4'hF, 1, 2'b10);
        rd(4'hA, 32'h100, 4'd3, 1'b0, -1, 0);
        wr(4'hB, 32'h200, 4'd1, 1'b0, 32'h77770000, 4'hF, 99, 2'b10);
        rd(4'hB, 32'h200, 4'd1, 1'b0, -1, 0);

        // FIXED write: every beat lands on the same word, last one wins.
        wr(4'hC, 32'h80, 4'd3, 1'b1, 32'h3C3C0000, 4'hF, -1, 2'b00);
        rd(4'hC, 32'h80, 4'd0, 1'b0, -1, 0);

        // Index wrap at the top of the RAM and address aliasing above it.
        wr(4'hD, 32'h0000_FFFC, 4'd1, 1'b0, 32'h50000000, 4'hF, -1, 2'b00);
        rd(4'hD, 32'h0001_0000, 4'd0, 1'b0, -1, 0);
        rd(4'hE, 32'h0000_FFFC, 4'd1, 1'b0, -1, 0);

        // Reset in the middle of an 8-beat read.
        bus.s_arid = 4'h6; bus.s_araddr = 32'h20; bus.s_arlen = 4'd7; bus.s_arburst = 2'b01;
        bus.s_arvalid = 1'b1; bus.s_rready = 1'b1;
        tick();
        bus.s_arvalid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            check("pre_rst_rdata", bus.s_rdata, mget(8 + b));
            tick();
        end
        check("pre_rst_beat4", bus.s_rdata, mget(12));
        resetn = 1'b0;
        #1;
        check("mid_rst_rvalid",  32'(bus.s_rvalid),  32'd0);
        check("mid_rst_rlast",   32'(bus.s_rlast),   32'd0);
        check("mid_rst_rdata",   bus.s_rdata,        32'd0);
        check("mid_rst_rid",     32'(bus.s_rid),     32'd0);
        check("mid_rst_arready", 32'(bus.s_arready), 32'd1);
        bus.s_rready = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        tick();
        check("post_rst_arready", 32'(bus.s_arready), 32'd1);
        rd(4'h2, 32'h20, 4'd7, 1'b0, -1, 0);
        rd(4'h3, 32'h0C, 4'd0, 1'b0, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axi_burst_ram_slave.md
# axi_burst_ram_slave

AXI3-subset responder backed by an internal word RAM, serving the burst reads and writes issued by the data/instruction cache masters and uncached single-beat accesses. Sits at the slave end of the cache AXI port in simulation and FPGA bring-up SoCs, standing in for the memory controller. Handles one transaction at a time, with read-over-write priority, INCR/FIXED bursts of up to 16 beats, and byte strobes.

## Interface
- MEM_AW, default 14: word-index width; RAM depth is 2^MEM_AW 32-bit words.
- STALL_CYCLES, default 2: wait states per handshake point; used only when `AXI_SLAVE_STALL_EN` is defined.
- Reset: one clock, `clk`; `resetn` is asynchronous and active-low.
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- s_arid  in  4  read ID.
- s_araddr  in  32  read start byte address.
- s_arlen  in  4  beats minus 1.
- s_arburst  in  2  00 FIXED, 01 INCR; 10/11 treated as INCR.
- s_arvalid / s_arready  in / out  1  AR handshake.
- s_rid  out  4  equals captured arid.
- s_rdata  out  32  read data.
- s_rresp  out  2  always 00.
- s_rlast  out  1  final beat.
- s_rvalid / s_rready  out / in  1  R handshake.
- s_awid  in  4  write ID.
- s_awaddr  in  32  write start byte address.
- s_awlen  in  4  beats minus 1.
- s_awburst  in  2  as arburst.
- s_awvalid / s_awready  in / out  1  AW handshake.
- s_wdata  in  32  write data.
- s_wstrb  in  4  byte enables.
- s_wlast  in  1  master's last flag.
- s_wvalid / s_wready  in / out  1  W handshake.
- s_bid  out  4  equals captured awid.
- s_bresp  out  2  00 OKAY, 10 SLVERR.
- s_bvalid / s_bready  out / in  1  B handshake.

## Operation
- FSM states: IDLE, RD_BURST, WR_DATA, WR_RESP.
- IDLE: s_arready=1; s_awready = !s_arvalid. Read wins when both are valid.
- AR handshake in IDLE: capture id, start address, len, and burst type; clear beat count; go to RD_BURST.
- AW handshake in IDLE: capture id, start address, len, and burst type; clear beat count and error flag; go to WR_DATA.
- Word index = addr[MEM_AW+1:2]. Upper bits are dropped, so accesses alias modulo the RAM size. addr[1:0] is ignored.
- INCR: index advances by 1 per beat, wrapping modulo 2^MEM_AW. FIXED: index is held.
- RD_BURST:
  - s_rvalid is held with registered s_rdata = mem[index] until s_rready.
  - On a handshake, the beat count increments and the next word is loaded.
  - s_rlast = (count == len).
  - A handshake on the last beat returns the FSM to IDLE.
- WR_DATA:
  - s_wready=1.
  - On a handshake, each byte b with s_wstrb[b]=1 writes mem[index][8b+7:8b]. Bytes with strobe 0 are untouched.
  - The burst ends when count == len; go to WR_RESP.
  - If s_wlast != (count == len) on any beat, set the error flag. Data is still written. Early wlast does not shorten the burst.
- WR_RESP: s_bvalid=1, s_bresp = error ? 10 : 00. A handshake returns the FSM to IDLE.
- RAM contents are not reset. Simulation may preload them via hierarchical access.

## Timing
- Reset values:
  - state IDLE.
  - s_arready=1, s_awready=1 (when s_arvalid is low).
  - s_rvalid, s_rlast, s_wready, s_bvalid = 0.
  - s_rdata, s_rid, s_bid, s_bresp, s_rresp = 0.
- Asserting resetn low mid-burst aborts immediately: every output returns to its reset value in the same cycle. The RAM keeps any beats already written.
- Read latency: AR handshake at cycle T gives first s_rvalid at T+1. Subsequent beats are back-to-back while s_rready=1, so len+1 beats span T+1..T+len+1. The next AR can be accepted at T+len+2.
- Write: AW handshake at T gives s_wready from T+1. The last W beat at cycle W gives s_bvalid at W+1.
- R and B outputs are stable while valid is high and ready is low.
- A read burst of exactly one beat asserts s_rlast on its only beat.

## Configuration
- `AXI_SLAVE_STALL_EN` defined:
  - A wait counter inserts STALL_CYCLES cycles of deasserted ready/valid before each AR/AW acceptance (while valid is seen), before each R beat's s_rvalid, before each W beat's s_wready, and before s_bvalid.
  - Each stall adds STALL_CYCLES cycles to the corresponding latency above.
  - STALL_CYCLES=0 behaves as undefined.
- Undefined: no wait counter is present; latencies are exactly as stated under Timing.

## Test plan
- Full-line read: preload mem[8..15]=0xA0..0xA7, AR addr 0x20, len 7, INCR, rready=1. Expect 8 beats A0..A7 on consecutive cycles, rlast only on A7, rid = arid.
- Partial write: mem[3]=0x11223344, AW 0x0C len 0, W 0xAABBCCDD strb 0011 wlast=1. Expect bresp 00 and mem[3]=0x1122CCDD.
- Simultaneous AR and AW in the same cycle: AW is not accepted. Read completes first, then AW is accepted the cycle after returning to IDLE.
- Backpressure: hold rready=0 for 3 cycles on beat 2. Expect rdata and rlast frozen, and no beat skipped. FIXED burst len 3 returns the same word 4 times.
- Protocol error: AW len 3 with wlast on beat 1. Expect all 4 beats written and bresp 10.
- Reset mid-read at beat 4 of 8: rvalid drops immediately. After release, arready=1 and a new read returns correct data.
